// File: rtl/draw_pkg.sv
// Widths and state encoding shared by the draw engines and the
// framebuffer write-port arbiter.
package draw_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: finds the first set request bit after ptr, wrapping.
// Purely combinational so it can be shared by other schedulers.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int               cand;
    logic [IDX_W-1:0] cidx;

    // The scan starts one past ptr, so the previous winner has lowest priority.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        cidx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            cidx = IDX_W'(cand);
            if (!found && req[cidx]) begin
                found = 1'b1;
                idx   = cidx;
            end
        end
    end

endmodule

// File: rtl/pixel_port_arbiter.sv
// Shares the framebuffer write port between draw engines: round-robin grant
// per burst, one register stage on the pixel path, watchdog-bounded bursts.
module pixel_port_arbiter
    import draw_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 256
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     last,
    input  logic [N_REQ*X_W-1:0] px,
    input  logic [N_REQ*Y_W-1:0] py,
    input  logic [N_REQ*C_W-1:0] pcol,
    input  logic [N_REQ-1:0]     pplot,
    output logic [N_REQ-1:0]     gnt,
    output logic [X_W-1:0]       x,
    output logic [Y_W-1:0]       y,
    output logic [C_W-1:0]       colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 timeout
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] own_q, own_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [C_W-1:0]   col_q, col_d;
    logic             plot_q, plot_d;
    logic             timeout_q, timeout_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    logic             own_req, own_last, own_pplot;
    logic [X_W-1:0]   own_x;
    logic [Y_W-1:0]   own_y;
    logic [C_W-1:0]   own_col;
    logic             end_last, end_drop, end_wdog;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        own_req   = req[own_q];
        own_last  = last[own_q];
        own_pplot = pplot[own_q];
        own_x     = px[int'(own_q)*X_W +: X_W];
        own_y     = py[int'(own_q)*Y_W +: Y_W];
        own_col   = pcol[int'(own_q)*C_W +: C_W];
    end

    // Ending conditions; a dropped request outranks the watchdog so that
    // timeout only flags bursts the owner would otherwise have kept.
    always_comb begin
        end_last = own_pplot & own_last & own_req;
        end_drop = ~own_req;
        end_wdog = (cnt_q == CNT_LAST) & ~end_last & ~end_drop;
    end

    always_comb begin
        gnt = '0;
        if (state_q == BURST) begin
            gnt[own_q] = 1'b1;
        end
        busy = (state_q == BURST);
    end

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        col_d     = col_q;
        plot_d    = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    own_d   = pick_idx;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                cnt_d  = cnt_q + 1'b1;
                plot_d = own_pplot & own_req;
                if (plot_d) begin
                    x_d   = own_x;
                    y_d   = own_y;
                    col_d = own_col;
                end
                timeout_d = end_wdog;
                if (end_last || end_drop || end_wdog) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            own_q     <= '0;
            ptr_q     <= IDX_W'(N_REQ - 1);
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            col_q     <= '0;
            plot_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            col_q     <= col_d;
            plot_q    <= plot_d;
            timeout_q <= timeout_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = col_q;
    assign plot    = plot_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_pixel_port_arbiter.sv
// Directed bench for pixel_port_arbiter: four requesters, short watchdog so
// forced release can be exercised in a few cycles.
module tb_pixel_port_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         resetn;
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic [N-1:0] pplot;
    logic [N*8-1:0] px;
    logic [N*7-1:0] py;
    logic [N*3-1:0] pcol;
    logic [N-1:0] gnt;
    logic [7:0]   x;
    logic [6:0]   y;
    logic [2:0]   colour;
    logic         plot;
    logic         busy;
    logic         timeout;

    logic [7:0] rx [N];
    logic [6:0] ry [N];
    logic [2:0] rc [N];

    int pass_count;
    int check_count;

    pixel_port_arbiter #(
        .N_REQ     (N),
        .MAX_BURST (4)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .last    (last),
        .px      (px),
        .py      (py),
        .pcol    (pcol),
        .pplot   (pplot),
        .gnt     (gnt),
        .x       (x),
        .y       (y),
        .colour  (colour),
        .plot    (plot),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        px   = {rx[3], rx[2], rx[1], rx[0]};
        py   = {ry[3], ry[2], ry[1], ry[0]};
        pcol = {rc[3], rc[2], rc[1], rc[0]};
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            pass_count++;
        end
    endtask

    task automatic applyStimulus(input int i, input logic r, input logic pl, input logic ls,
                                 input logic [7:0] xv, input logic [6:0] yv, input logic [2:0] cv);
        req[i]   = r;
        pplot[i] = pl;
        last[i]  = ls;
        rx[i]    = xv;
        ry[i]    = yv;
        rc[i]    = cv;
    endtask

    task automatic clearAll();
        for (int i = 0; i < N; i++) begin
            applyStimulus(i, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_exp [9];

    initial begin
        pass_count  = 0;
        check_count = 0;
        rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001};

        // Reset state
        resetn = 1'b0;
        clearAll();
        repeat (3) nextCycle();
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_plot", plot, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_xyc", {x, y, colour}, 0);

        // Requester 0, three pixels, last on the third
        resetn = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        nextCycle();
        checkOutput("b1_gnt", gnt, 4'b0001);
        checkOutput("b1_busy", busy, 1);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'd10, 7'd5, 3'd1);
        nextCycle();
        checkOutput("b1_p1", {plot, x, y, colour}, {1'b1, 8'd10, 7'd5, 3'd1});
        checkOutput("b1_gnt_hold", gnt, 4'b0001);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'd11, 7'd5, 3'd1);
        nextCycle();
        checkOutput("b1_p2", {plot, x, y, colour}, {1'b1, 8'd11, 7'd5, 3'd1});
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 8'd12, 7'd5, 3'd1);
        nextCycle();
        checkOutput("b1_p3", {plot, x, y, colour}, {1'b1, 8'd12, 7'd5, 3'd1});
        checkOutput("b1_gnt_end", gnt, 0);
        checkOutput("b1_busy_end", busy, 0);
        clearAll();
        nextCycle();
        checkOutput("b1_plot_off", plot, 0);

        // Round robin with all four requesting single-pixel bursts
        resetn = 1'b0;
        nextCycle();
        resetn = 1'b1;
        for (int i = 0; i < N; i++) begin
            applyStimulus(i, 1'b1, 1'b1, 1'b1, 8'(20 + i), 7'(10 + i), 3'(i));
        end
        for (int s = 0; s < 9; s++) begin
            nextCycle();
            checkOutput("rr_gnt", gnt, rr_exp[s]);
            checkOutput("rr_onehot", $onehot0(gnt), 1);
            if (s > 0) begin
                checkOutput("rr_plot", plot, rr_exp[s-1] != 0);
                if (rr_exp[s-1] != 0) begin
                    checkOutput("rr_x", x, 20 + $clog2(rr_exp[s-1]));
                end
            end
        end
        clearAll();
        nextCycle();
        checkOutput("rr_end_gnt", gnt, 0);
        checkOutput("rr_end_plot", plot, 0);

        // Requester 2 drops req mid-burst, requester 3 pending
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        nextCycle();
        checkOutput("drop_gnt2", gnt, 4'b0100);
        applyStimulus(2, 1'b1, 1'b1, 1'b0, 8'd30, 7'd20, 3'd5);
        applyStimulus(3, 1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        nextCycle();
        checkOutput("drop_p1", {plot, x, y, colour}, {1'b1, 8'd30, 7'd20, 3'd5});
        checkOutput("drop_gnt_hold", gnt, 4'b0100);
        applyStimulus(2, 1'b0, 1'b1, 1'b0, 8'd31, 7'd21, 3'd6);
        nextCycle();
        checkOutput("drop_gnt_off", gnt, 0);
        checkOutput("drop_plot", plot, 0);
        checkOutput("drop_x_hold", x, 30);
        nextCycle();
        checkOutput("drop_gnt3", gnt, 4'b1000);
        clearAll();
        nextCycle();
        checkOutput("drop_end_busy", busy, 0);

        // Watchdog: requester 1 streams without last
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 8'd40, 7'd0, 3'd2);
        nextCycle();
        checkOutput("wd_gnt", gnt, 4'b0010);
        checkOutput("wd_timeout0", timeout, 0);
        for (int s = 1; s <= 5; s++) begin
            rx[1] = 8'(40 + s);
            nextCycle();
            if (s <= 4) begin
                checkOutput("wd_plot", plot, 1);
                checkOutput("wd_x", x, 40 + s);
                checkOutput("wd_timeout", timeout, s == 4);
                checkOutput("wd_gnt_s", gnt, (s < 4) ? 4'b0010 : 4'b0000);
            end else begin
                checkOutput("wd_regrant", gnt, 4'b0010);
                checkOutput("wd_plot_idle", plot, 0);
                checkOutput("wd_timeout_off", timeout, 0);
                checkOutput("wd_x_hold", x, 44);
            end
        end
        clearAll();
        nextCycle();
        checkOutput("wd_end_gnt", gnt, 0);

        // Reset asserted during requester 0's second pixel
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        nextCycle();
        checkOutput("rb_gnt", gnt, 4'b0001);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'd50, 7'd30, 3'd3);
        nextCycle();
        checkOutput("rb_p1", {plot, x}, {1'b1, 8'd50});
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'd51, 7'd31, 3'd4);
        resetn = 1'b0;
        nextCycle();
        checkOutput("rb_gnt_off", gnt, 0);
        checkOutput("rb_busy", busy, 0);
        checkOutput("rb_out", {plot, x, y, colour}, 0);
        resetn = 1'b1;
        clearAll();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        nextCycle();
        checkOutput("rb_first", gnt, 4'b0001);
        clearAll();
        nextCycle();

        // last without pplot keeps the burst open
        applyStimulus(3, 1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
        nextCycle();
        checkOutput("lp_gnt", gnt, 4'b1000);
        applyStimulus(3, 1'b1, 1'b1, 1'b0, 8'd60, 7'd40, 3'd7);
        nextCycle();
        checkOutput("lp_p1", {plot, x}, {1'b1, 8'd60});
        applyStimulus(3, 1'b1, 1'b0, 1'b1, 8'd61, 7'd41, 3'd1);
        nextCycle();
        checkOutput("lp_noplot", plot, 0);
        checkOutput("lp_gnt_hold", gnt, 4'b1000);
        checkOutput("lp_x_hold", x, 60);
        applyStimulus(3, 1'b1, 1'b1, 1'b1, 8'd62, 7'd42, 3'd2);
        nextCycle();
        checkOutput("lp_final", {plot, x, y, colour}, {1'b1, 8'd62, 7'd42, 3'd2});
        checkOutput("lp_gnt_end", gnt, 0);
        clearAll();
        nextCycle();
        checkOutput("lp_plot_off", plot, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
